riscv_mul_arb: RTL and testbench

//  Shares the single 2-stage integer multiplier (riscv_mul) between NREQ requesters.

---
 rtl/riscv_mul_arb_pkg.sv | 37 +++
 rtl/riscv_mul_arb_if.sv | 39 +++
 rtl/riscv_mul_arb_fifo.sv | 65 ++++++
 rtl/riscv_mul_arb.sv | 134 +++++++++++++
 tb/tb_riscv_mul_arb.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_mul_arb_pkg.sv
// Shared defaults, multiply opcode encodings and decode helpers for the
// multiplier arbiter.
package riscv_mul_arb_pkg;

  localparam int MUL_ARB_NREQ  = 2;
  localparam int MUL_ARB_DEPTH = 4;

  // R-type M-extension multiplies: funct7=0000001, opcode=0110011
  localparam logic [31:0] INST_MUL_MASK = 32'hFE00707F;
  localparam logic [31:0] INST_MUL      = 32'h02000033;
  localparam logic [31:0] INST_MULH     = 32'h02001033;
  localparam logic [31:0] INST_MULHSU   = 32'h02002033;
  localparam logic [31:0] INST_MULHU    = 32'h02003033;

  typedef enum logic [2:0] {
    MK_MUL,
    MK_MULH,
    MK_MULHSU,
    MK_MULHU,
    MK_NONE
  } mul_kind_e;

  function automatic mul_kind_e mul_kind(input logic [31:0] inst);
    logic [31:0] m;
    m = inst & INST_MUL_MASK;
    if (m == INST_MUL)         return MK_MUL;
    else if (m == INST_MULH)   return MK_MULH;
    else if (m == INST_MULHSU) return MK_MULHSU;
    else if (m == INST_MULHU)  return MK_MULHU;
    else                       return MK_NONE;
  endfunction

  function automatic logic is_mul_op(input logic [31:0] inst);
    return mul_kind(inst) != MK_NONE;
  endfunction

endpackage

// File: rtl/riscv_mul_arb_if.sv
// Bundle of requester, multiplier and response signals of the arbiter.
// slave: the arbiter's view; master: the surrounding system's view.
interface riscv_mul_arb_if
  import riscv_mul_arb_pkg::*;
#(
  parameter int NREQ = MUL_ARB_NREQ,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);

  logic [NREQ-1:0]    req_valid;
  logic [32*NREQ-1:0] req_opcode;
  logic [32*NREQ-1:0] req_ra;
  logic [32*NREQ-1:0] req_rb;
  logic [NREQ-1:0]    req_ready;

  logic               mul_valid;
  logic [31:0]        mul_opcode;
  logic [31:0]        mul_ra;
  logic [31:0]        mul_rb;
  logic [31:0]        mul_result;

  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_result;
  logic               rsp_ready;

  modport slave (
    input  req_valid, req_opcode, req_ra, req_rb, mul_result, rsp_ready,
    output req_ready, mul_valid, mul_opcode, mul_ra, mul_rb,
           rsp_valid, rsp_id, rsp_result
  );

  modport master (
    output req_valid, req_opcode, req_ra, req_rb, mul_result, rsp_ready,
    input  req_ready, mul_valid, mul_opcode, mul_ra, mul_rb,
           rsp_valid, rsp_id, rsp_result
  );

endinterface

// File: rtl/riscv_mul_arb_fifo.sv
// Circular response FIFO of {id, result}; head is presented combinationally
// and reads as zero while empty.
module riscv_mul_arb_fifo
  import riscv_mul_arb_pkg::*;
#(
  parameter int DEPTH = MUL_ARB_DEPTH,
  parameter int W     = 33,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          valid,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer/count/storage update; pop on empty is ignored
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_data;
  end

  // State registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid     = (count_q != '0);
  assign head_data = valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (arst)
    push |-> ((count_q != CW'(DEPTH)) || pop));

endmodule

// File: rtl/riscv_mul_arb.sv
// Round-robin arbiter sharing one 2-stage multiplier among NREQ requesters.
// The multiplier sits on the mul_* ports (its hold input tied low): an op
// issued at edge E0 has its product on mul_result after E1. Requester ids
// ride a two-entry tracker alongside the pipe and land in a credit-guarded
// response FIFO, so the multiplier never has to stall.
module riscv_mul_arb
  import riscv_mul_arb_pkg::*;
#(
  parameter int NREQ  = MUL_ARB_NREQ,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int DEPTH = MUL_ARB_DEPTH
) (
  input  logic           clk,
  input  logic           arst,
  riscv_mul_arb_if.slave bus
);

  localparam int          CW = $clog2(DEPTH + 1);
  localparam int          OW = CW + 1;
  localparam int unsigned NR = NREQ;

  logic [IDW-1:0]  rr_q, rr_d;
  logic            s1_v_q, s1_v_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            s2_v_q, s2_v_d;
  logic [IDW-1:0]  s2_id_q, s2_id_d;

  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ready;
  logic [IDW-1:0]  gid;
  logic            accept;
  logic            pop;
  logic            credit_ok;
  logic [OW-1:0]   occ;
  logic [31:0]     sel_opcode, sel_ra, sel_rb;

  logic            fifo_valid;
  logic [CW-1:0]   fifo_count;
  logic [IDW+31:0] fifo_head;

  // Round-robin pick: first valid requester after the last one granted
  always_comb begin
    int unsigned idx;
    logic        found;
    grant = '0;
    gid   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NR; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NR) idx = idx - NR;
      if (!found && bus.req_valid[IDW'(idx)]) begin
        found               = 1'b1;
        grant[IDW'(idx)]    = 1'b1;
        gid                 = IDW'(idx);
      end
    end
  end

  // Credit check and issue mux: everything in flight plus the FIFO must fit
  always_comb begin
    pop        = fifo_valid & bus.rsp_ready;
    occ        = OW'(fifo_count) + OW'(s1_v_q) + OW'(s2_v_q) - OW'(pop);
    credit_ok  = (occ < OW'(DEPTH));
    ready      = (credit_ok && !arst) ? grant : '0;
    accept     = |ready;
    sel_opcode = '0;
    sel_ra     = '0;
    sel_rb     = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (ready[i]) begin
        sel_opcode = sel_opcode | bus.req_opcode[32*i +: 32];
        sel_ra     = sel_ra     | bus.req_ra[32*i +: 32];
        sel_rb     = sel_rb     | bus.req_rb[32*i +: 32];
      end
    end
  end

  // Pointer and id-tracker next state, mirroring the multiplier's two stages
  always_comb begin
    rr_d    = accept ? gid : rr_q;
    s1_v_d  = accept;
    s1_id_d = accept ? gid : '0;
    s2_v_d  = s1_v_q;
    s2_id_d = s1_id_q;
  end

  // State registers. rr holds the last granted id; resetting it to NREQ-1
  // makes requester 0 the first in line.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rr_q    <= IDW'(NREQ - 1);
      s1_v_q  <= 1'b0;
      s1_id_q <= '0;
      s2_v_q  <= 1'b0;
      s2_id_q <= '0;
    end else begin
      rr_q    <= rr_d;
      s1_v_q  <= s1_v_d;
      s1_id_q <= s1_id_d;
      s2_v_q  <= s2_v_d;
      s2_id_q <= s2_id_d;
    end
  end

  riscv_mul_arb_fifo #(
    .DEPTH (DEPTH),
    .W     (IDW + 32)
  ) u_fifo (
    .clk       (clk),
    .arst      (arst),
    .push      (s2_v_q),
    .push_data ({s2_id_q, bus.mul_result}),
    .pop       (pop),
    .valid     (fifo_valid),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign bus.req_ready  = ready;
  assign bus.mul_valid  = accept;
  assign bus.mul_opcode = sel_opcode;
  assign bus.mul_ra     = sel_ra;
  assign bus.mul_rb     = sel_rb;
  assign bus.rsp_valid  = fifo_valid;
  assign bus.rsp_id     = fifo_head[32 +: IDW];
  assign bus.rsp_result = fifo_head[31:0];

  a_grant_onehot: assert property (@(posedge clk) disable iff (arst)
    $onehot0(ready));
  a_grant_is_mul: assert property (@(posedge clk) disable iff (arst)
    accept |-> is_mul_op(sel_opcode));

endmodule

// File: tb/tb_riscv_mul_arb.sv
// Bench for riscv_mul_arb: a stand-in 2-stage multiplier, requester queues,
// a transaction-level model compared every cycle, and directed scenarios.
module tb_riscv_mul_arb;

  localparam int NREQ  = 2;
  localparam int IDW   = 1;
  localparam int DEPTH = 4;

  localparam logic [31:0] OP_MUL    = 32'h020000B3;
  localparam logic [31:0] OP_MULH   = 32'h020010B3;
  localparam logic [31:0] OP_MULHSU = 32'h020020B3;
  localparam logic [31:0] OP_MULHU  = 32'h020030B3;

  logic clk = 1'b0;
  logic arst;

  riscv_mul_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus();

  riscv_mul_arb #(.NREQ(NREQ), .IDW(IDW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Product as the M extension defines it, from 64-bit extended operands
  function automatic logic [31:0] ref_mul(input logic [31:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op[14:12])
      3'd0:    begin p = sa * sb; return p[31:0];  end
      3'd1:    begin p = sa * sb; return p[63:32]; end
      3'd2:    begin p = sa * ub; return p[63:32]; end
      3'd3:    begin p = ua * ub; return p[63:32]; end
      default: return 32'h0;
    endcase
  endfunction

  // Stand-in multiplier: operands captured at one edge, product out after the next
  logic [31:0] st1;
  always @(posedge clk) begin
    st1            <= ref_mul(bus.mul_opcode, bus.mul_ra, bus.mul_rb);
    bus.mul_result <= st1;
  end

  typedef struct {
    logic [31:0] op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    res;
    int unsigned    cyc;
  } exp_t;

  req_t        rq[NREQ][$];
  logic        rsp_rdy_v = 1'b0;
  logic [NREQ-1:0] acc_mask = '0;

  exp_t        mq[$];
  int unsigned cyc = 0;
  int unsigned last = NREQ - 1;
  int unsigned acc_id_log[$];
  int unsigned acc_cyc_log[$];
  int unsigned rsp_id_log[$];
  logic [31:0] rsp_res_log[$];
  int unsigned rsp_cyc_log[$];

  // Model: every accepted op is owed back in acceptance order, no earlier than
  // three cycles later; new work is granted only while the total owed (minus a
  // pop this cycle) stays below DEPTH.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_grant;
    int unsigned     gj;
    logic            exp_rv, exp_pop;
    logic [31:0]     e_op, e_a, e_b;
    cyc++;
    if (arst) begin
      mq.delete();
      last     = NREQ - 1;
      acc_mask = '0;
    end else begin
      exp_grant = '0;
      gj        = 0;
      for (int k = 1; k <= NREQ; k++) begin
        int unsigned j;
        j = (last + k) % NREQ;
        if (exp_grant == '0 && bus.req_valid[IDW'(j)]) begin
          exp_grant = NREQ'(1) << j;
          gj        = j;
        end
      end
      exp_rv  = (mq.size() > 0) && (mq[0].cyc + 3 <= cyc);
      exp_pop = exp_rv && bus.rsp_ready;
      if (int'(mq.size()) - int'(exp_pop) >= DEPTH) exp_grant = '0;
      e_op = (exp_grant != '0) ? bus.req_opcode[32*gj +: 32] : 32'h0;
      e_a  = (exp_grant != '0) ? bus.req_ra[32*gj +: 32] : 32'h0;
      e_b  = (exp_grant != '0) ? bus.req_rb[32*gj +: 32] : 32'h0;

      chk("req_ready", 32'(bus.req_ready), 32'(exp_grant));
      chk("mul_valid", 32'(bus.mul_valid), 32'(exp_grant != '0));
      chk("mul_opcode", bus.mul_opcode, e_op);
      chk("mul_ra", bus.mul_ra, e_a);
      chk("mul_rb", bus.mul_rb, e_b);
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("rsp_id", 32'(bus.rsp_id), 32'(mq[0].id));
        chk("rsp_result", bus.rsp_result, mq[0].res);
      end

      if (exp_grant != '0) begin
        mq.push_back('{id: IDW'(gj), res: ref_mul(e_op, e_a, e_b), cyc: cyc});
        last = gj;
        acc_id_log.push_back(gj);
        acc_cyc_log.push_back(cyc);
      end
      if (exp_pop) begin
        void'(mq.pop_front());
        rsp_id_log.push_back(32'(bus.rsp_id));
        rsp_res_log.push_back(bus.rsp_result);
        rsp_cyc_log.push_back(cyc);
      end
      acc_mask = bus.req_valid & bus.req_ready;
    end
  end

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        bus.req_valid[IDW'(i)]      = 1'b1;
        bus.req_opcode[32*i +: 32]  = rq[i][0].op;
        bus.req_ra[32*i +: 32]      = rq[i][0].a;
        bus.req_rb[32*i +: 32]      = rq[i][0].b;
      end else begin
        bus.req_valid[IDW'(i)]      = 1'b0;
        bus.req_opcode[32*i +: 32]  = 32'h0;
        bus.req_ra[32*i +: 32]      = 32'h0;
        bus.req_rb[32*i +: 32]      = 32'h0;
      end
    end
    bus.rsp_ready = rsp_rdy_v;
  endtask

  // One cycle: retire what was accepted at this edge, present next payloads
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acc_mask[IDW'(i)] && rq[i].size() > 0) void'(rq[i].pop_front());
    drive();
  endtask

  task automatic wait_rsp(input int unsigned n, input int unsigned max_cyc, input string name);
    int unsigned k;
    k = 0;
    while (rsp_res_log.size() < n && k < max_cyc) begin
      step();
      k++;
    end
    chk(name, 32'(rsp_res_log.size() >= n), 32'd1);
  endtask

  task automatic push_op(input int r, input logic [31:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    rq[r].push_back('{op: op, a: a, b: b});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned a0, r0, n;
    arst = 1'b1;
    bus.req_valid  = '0;
    bus.req_opcode = '0;
    bus.req_ra     = '0;
    bus.req_rb     = '0;
    bus.rsp_ready  = 1'b0;

    // Contention setup: both requesters valid while still in reset
    push_op(0, OP_MULH, 32'hFFFFFFFF, 32'd2);
    push_op(0, OP_MULH, 32'hFFFFFFFF, 32'd2);
    push_op(1, OP_MULHU, 32'hFFFFFFFF, 32'd2);
    push_op(1, OP_MULHU, 32'hFFFFFFFF, 32'd2);
    rsp_rdy_v = 1'b1;
    repeat (2) step();
    #1;
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_mul_valid", 32'(bus.mul_valid), 32'd0);
    chk("reset_mul_opcode", bus.mul_opcode, 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("reset_rsp_result", bus.rsp_result, 32'd0);
    arst = 1'b0;

    // Contention: grants alternate starting at requester 0
    wait_rsp(4, 30, "contention_done");
    for (int k = 0; k < 4; k++) begin
      chk("contention_grant_order", 32'(acc_id_log[k]), 32'(k % 2));
      chk("contention_rsp_id", 32'(rsp_id_log[k]), 32'(k % 2));
      chk("contention_rsp_result", rsp_res_log[k], (k % 2 == 0) ? 32'hFFFFFFFF : 32'h00000001);
    end
    repeat (3) step();

    // Single op and its latency
    a0 = acc_id_log.size();
    r0 = rsp_res_log.size();
    push_op(0, OP_MUL, 32'd7, 32'd6);
    wait_rsp(r0 + 1, 20, "single_done");
    chk("single_id", 32'(rsp_id_log[r0]), 32'd0);
    chk("single_result", rsp_res_log[r0], 32'd42);
    chk("single_latency", rsp_cyc_log[r0] - acc_cyc_log[a0], 32'd3);
    repeat (3) step();

    // Backpressure: exactly DEPTH accepts, then stall until drained
    a0 = acc_id_log.size();
    r0 = rsp_res_log.size();
    rsp_rdy_v = 1'b0;
    for (int i = 0; i < 6; i++) push_op(0, OP_MUL, 32'(i + 1), 32'd3);
    repeat (12) step();
    #1;
    chk("bp_accepts", acc_id_log.size() - a0, 32'd4);
    chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
    chk("bp_rsp_held_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_rsp_held_result", bus.rsp_result, 32'd3);
    rsp_rdy_v = 1'b1;
    wait_rsp(r0 + 6, 40, "bp_done");
    for (int i = 0; i < 6; i++)
      chk("bp_result_order", rsp_res_log[r0 + i], 32'((i + 1) * 3));
    repeat (3) step();

    // Streaming: 20 ops back to back from both requesters
    a0 = acc_id_log.size();
    r0 = rsp_res_log.size();
    push_op(0, OP_MULHSU, 32'h80000000, 32'h80000000);
    for (int i = 1; i < 10; i++) push_op(0, OP_MUL, 32'(i), 32'(i + 100));
    for (int i = 0; i < 10; i++) push_op(1, OP_MULHU, 32'(i) * 32'h10000001, 32'h12345);
    wait_rsp(r0 + 20, 60, "stream_done");
    chk("stream_accept_span", acc_cyc_log[a0 + 19] - acc_cyc_log[a0], 32'd19);
    chk("stream_first_grant", 32'(acc_id_log[a0]), 32'd1);
    chk("stream_mulhsu_id", 32'(rsp_id_log[r0 + 1]), 32'd0);
    chk("stream_mulhsu_result", rsp_res_log[r0 + 1], 32'hC0000000);
    chk("stream_mul_result", rsp_res_log[r0 + 3], 32'd101);
    repeat (3) step();

    // Reset one edge after an accept: nothing comes back for the lost op
    a0 = acc_id_log.size();
    push_op(0, OP_MUL, 32'd5, 32'd5);
    n = 0;
    while (acc_id_log.size() == a0 && n < 10) begin
      step();
      n++;
    end
    chk("midreset_accepted", 32'(acc_id_log.size() - a0), 32'd1);
    @(posedge clk);
    #1 arst = 1'b1;
    #1;
    chk("midreset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("midreset_mul_valid", 32'(bus.mul_valid), 32'd0);
    chk("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midreset_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("midreset_rsp_result", bus.rsp_result, 32'd0);
    repeat (2) step();
    arst = 1'b0;
    r0 = rsp_res_log.size();
    repeat (8) step();
    chk("midreset_no_rsp", rsp_res_log.size() - r0, 32'd0);
    push_op(0, OP_MUL, 32'd9, 32'd9);
    wait_rsp(r0 + 1, 20, "midreset_next_done");
    chk("midreset_next_result", rsp_res_log[r0], 32'd81);
    repeat (3) step();

    // Full FIFO with a pop in the same cycle still grants; then fairness
    a0 = acc_id_log.size();
    r0 = rsp_res_log.size();
    rsp_rdy_v = 1'b0;
    for (int i = 0; i < 4; i++) push_op(0, OP_MUL, 32'(i + 2), 32'd10);
    repeat (10) step();
    chk("fair_fill_accepts", acc_id_log.size() - a0, 32'd4);
    push_op(1, OP_MUL, 32'd3, 32'd7);
    push_op(1, OP_MUL, 32'd4, 32'd7);
    rsp_rdy_v = 1'b1;
    step();
    #1;
    chk("full_pop_grant", 32'(bus.req_ready), 32'b10);
    push_op(0, OP_MUL, 32'd11, 32'd11);
    step();
    #1;
    chk("rr_fair_grant", 32'(bus.req_ready), 32'b01);
    wait_rsp(r0 + 7, 40, "fair_done");
    chk("fair_id4", 32'(rsp_id_log[r0 + 4]), 32'd1);
    chk("fair_res4", rsp_res_log[r0 + 4], 32'd21);
    chk("fair_id5", 32'(rsp_id_log[r0 + 5]), 32'd0);
    chk("fair_res5", rsp_res_log[r0 + 5], 32'd121);
    chk("fair_res6", rsp_res_log[r0 + 6], 32'd28);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
